// File: rtl/ps2_pkg.sv
// Shared Set-2 scan-code constants, decoder state type and key-index helpers
// for the PS/2 game-key decoder.
package ps2_pkg;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_P     = 8'h4D;
   localparam logic [7:0] SC_ENTER = 8'h5A;

   localparam int K_SPACE = 0;
   localparam int K_UP    = 1;
   localparam int K_P     = 2;
   localparam int K_ENTER = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_e;

   // One-hot key mask for a byte; E0 29 is deliberately not SPACE.
   function automatic logic [3:0] keyMask(input logic [7:0] c, input logic ext);
      logic [3:0] m;
      m = '0;
      if (ext) begin
         if (c == SC_UP) m[K_UP] = 1'b1;
      end else begin
         if (c == SC_SPACE) m[K_SPACE] = 1'b1;
         if (c == SC_P)     m[K_P]     = 1'b1;
         if (c == SC_ENTER) m[K_ENTER] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Prefix timeout counter: counts while enabled and not cleared, and pulses
// expire_o for one cycle on the last count before wrapping back to zero.
module ps2_prefix_timer #(
   parameter int PREFIX_TIMEOUT = 500000,
   parameter int TO_W           = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam logic [TO_W-1:0] LAST = TO_W'(PREFIX_TIMEOUT - 1);

   logic [TO_W-1:0] cnt_q, cnt_d;

   assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + TO_W'(1);
      if (clear_i || !enable_i || expire_o) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder for four game keys with registered action pulses.
// Optional PS2_TYPEMATIC_FLAP_EN: repeated makes of SPACE/UP also pulse flap.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int PREFIX_TIMEOUT = 500000,
   parameter int TO_W           = 20
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       code_valid,
   input  logic [7:0] code,
   output logic [3:0] key_held,
   output logic       flap_pulse,
   output logic       pause_toggle,
   output logic       restart_pulse,
   output logic       paused,
   output logic       proto_err
);

   ps2_state_e state_q, state_d;
   logic [3:0] held_q, held_d;
   logic       flap_q, flap_d;
   logic       pause_q, pause_d;
   logic       restart_q, restart_d;
   logic       paused_q, paused_d;
   logic       err_q, err_d;

   logic       expire;
   logic       isMake, isBreak, isExt;
   logic [3:0] keyHit, fresh;

   ps2_prefix_timer #(
      .PREFIX_TIMEOUT(PREFIX_TIMEOUT),
      .TO_W          (TO_W)
   ) u_timer (
      .clk     (CLOCK_50),
      .rst_n   (resetn),
      .clear_i (code_valid),
      .enable_i(state_q != IDLE),
      .expire_o(expire)
   );

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      isMake  = 1'b0;
      isBreak = 1'b0;
      isExt   = 1'b0;
      if (code_valid) begin
         unique case (state_q)
            IDLE: begin
               if (code == SC_EXT)      state_d = EXT;
               else if (code == SC_BRK) state_d = BRK;
               else                     isMake = 1'b1;
            end
            EXT: begin
               if (code == SC_BRK)      state_d = EXT_BRK;
               else if (code == SC_EXT) err_d = 1'b1;
               else begin
                  isMake  = 1'b1;
                  isExt   = 1'b1;
                  state_d = IDLE;
               end
            end
            BRK, EXT_BRK: begin
               state_d = IDLE;
               if (code == SC_EXT || code == SC_BRK) err_d = 1'b1;
               else begin
                  isBreak = 1'b1;
                  isExt   = (state_q == EXT_BRK);
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (expire) begin
         // A byte arriving on the expiry cycle takes the branch above instead.
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   always_comb begin
      keyHit    = keyMask(code, isExt);
      fresh     = keyHit & ~held_q;
      held_d    = held_q;
      flap_d    = 1'b0;
      pause_d   = 1'b0;
      restart_d = 1'b0;
      if (isMake) begin
         held_d    = held_q | keyHit;
`ifdef PS2_TYPEMATIC_FLAP_EN
         flap_d    = keyHit[K_SPACE] | keyHit[K_UP];
`else
         flap_d    = fresh[K_SPACE] | fresh[K_UP];
`endif
         pause_d   = fresh[K_P];
         restart_d = fresh[K_ENTER];
      end
      if (isBreak) held_d = held_q & ~keyHit;
      paused_d = paused_q ^ pause_d;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         held_q    <= '0;
         flap_q    <= 1'b0;
         pause_q   <= 1'b0;
         restart_q <= 1'b0;
         paused_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         flap_q    <= flap_d;
         pause_q   <= pause_d;
         restart_q <= restart_d;
         paused_q  <= paused_d;
         err_q     <= err_d;
      end
   end

   assign key_held      = held_q;
   assign flap_pulse    = flap_q;
   assign pause_toggle  = pause_q;
   assign restart_pulse = restart_q;
   assign paused        = paused_q;
   assign proto_err     = err_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 packet receiver; consumes its validated scan-code byte stream.
- Interprets Set-2 make/break/extended prefixes (E0, F0), tracks held state of four game keys, emits single-cycle game-control pulses (flap, pause toggle, restart) to the game FSM.
- Filters typematic repeats so a held key produces exactly one action per press.

Parameters:
- PREFIX_TIMEOUT, 500000, cycles of CLOCK_50 (10 ms) allowed between a prefix byte and its following byte before the sequence is abandoned
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > PREFIX_TIMEOUT

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- code_valid  in  1  single-cycle strobe: code carries a good byte from the receiver
- code  in  8  scan-code byte, sampled only when code_valid=1
- key_held  out  4  held flags: [0] SPACE (29), [1] UP (E0 75), [2] P (4D), [3] ENTER (5A)
- flap_pulse  out  1  one-cycle pulse on fresh press of SPACE or UP
- pause_toggle  out  1  one-cycle pulse on fresh press of P
- restart_pulse  out  1  one-cycle pulse on fresh press of ENTER
- paused  out  1  level, flips on every pause_toggle
- proto_err  out  1  one-cycle pulse on illegal byte sequence or prefix timeout

Behaviour:
- Clock/reset: one clock CLOCK_50; reset is asynchronous, active-low on resetn. All outputs and state reset to 0; FSM to IDLE; timeout counter to 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Advances only on cycles with code_valid=1 or on timeout.
- IDLE: E0 -> EXT; F0 -> BRK; other byte = make code of normal key -> IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT plus proto_err; other byte = extended make -> IDLE.
- BRK: E0 or F0 -> IDLE plus proto_err; other byte = normal break -> IDLE.
- EXT_BRK: E0 or F0 -> IDLE plus proto_err; other byte = extended break -> IDLE.
- Make of a tracked key: if its key_held bit = 0, set bit next cycle and assert the action pulse in that same cycle. If already 1 (typematic repeat), no pulse, no change.
- Break of a tracked key clears its key_held bit; no pulse.
- Untracked codes (including E0 29, which is not SPACE) are ignored apart from FSM sequencing.
- Latency: pulses and key_held updates are registered; visible exactly 1 cycle after the code_valid cycle.
- paused toggles in the same cycle pause_toggle is asserted.
- Timeout: counter clears on every code_valid and whenever the FSM is in IDLE; otherwise it increments each cycle. When it reaches PREFIX_TIMEOUT-1, the FSM returns to IDLE, proto_err pulses once, and the counter clears.
- Simultaneous timeout and code_valid in one cycle: code_valid wins; the byte is decoded in the current state and no proto_err is raised.
- SPACE and UP both map to flap. A fresh press of either pulses flap_pulse even if the other is held; pulses never merge beyond one cycle.
- Reset mid-sequence: prefix context is discarded; held flags are cleared; no pulses are generated on release of reset.

Optional Feature:
- Macro: PS2_TYPEMATIC_FLAP_EN.
- Defined: a repeated make of SPACE or UP while already held also pulses flap_pulse (auto-flap at the keyboard repeat rate). P and ENTER remain edge-only.
- Undefined: all four keys are strictly edge-triggered, exactly as in Behaviour.

Decomposition:
- Shared package ps2_pkg:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_SPACE=29, SC_UP=75, SC_P=4D, SC_ENTER=5A
  - FSM state enum (IDLE/EXT/BRK/EXT_BRK)
  - key-index constants K_SPACE=0, K_UP=1, K_P=2, K_ENTER=3
- One natural sub-module: ps2_prefix_timer, holding the timeout counter with clear/enable inputs and a one-cycle expire output.

Test Plan:
- Reset, then code 29 -> key_held=0001, flap_pulse high exactly 1 cycle, 1 cycle after strobe; then F0, 29 -> key_held=0000, no pulse.
- 29, 29, 29 (typematic) -> one flap_pulse only (three with PS2_TYPEMATIC_FLAP_EN); key_held[0] stays 1.
- E0, 75 -> key_held[1]=1 and flap_pulse; E0, F0, 75 -> key_held[1]=0; E0, 29 -> no flap, key_held unchanged.
- 4D, F0, 4D, 4D -> two pause_toggle pulses; paused goes 1 then 0; key_held[2] ends 1.
- E0, then no byte for PREFIX_TIMEOUT cycles -> proto_err one pulse, FSM IDLE; next byte 5A -> restart_pulse. Also F0, F0 -> proto_err, state IDLE.
- Assert resetn=0 between F0 and 29 while SPACE is held -> key_held=0000 asynchronously; after release, byte 29 is decoded as a make (flap_pulse), not a break.
